// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR   = 32'h0000_0013;  // ADDI x0,x0,0
  localparam logic [XLEN-1:0] ECALL_INSTR = 32'h0000_0073;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  // Redirect targets drop bit 0, as JALR does.
  function automatic logic [XLEN-1:0] redirect_pc(input logic [XLEN-1:0] target);
    return target & ~XLEN'(1);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and the rest of the core / instruction ROM.
interface fetch_stage_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  stall;
  logic                  flush;
  logic [DATA_WIDTH-1:0] pc_target;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic [DATA_WIDTH-1:0] instr_d;
  logic [DATA_WIDTH-1:0] pc_d;
  logic [DATA_WIDTH-1:0] pc_plus4_d;
  logic                  valid_d;
  logic                  halted;
  logic                  misaligned;
  logic [31:0]           fetch_count;

  // Fetch-stage side.
  modport master (
    input  stall, flush, pc_target, imem_rdata,
    output imem_addr, instr_d, pc_d, pc_plus4_d, valid_d,
           halted, misaligned, fetch_count
  );

  // Core / ROM side.
  modport slave (
    output stall, flush, pc_target, imem_rdata,
    input  imem_addr, instr_d, pc_d, pc_plus4_d, valid_d,
           halted, misaligned, fetch_count
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble wins over load, otherwise hold.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t data,
  output if_id_t ifid
);

  if_id_t ifid_q;

  // A bubble replaces only the instruction and valid bit; the PCs keep their old values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ifid_q.instr    <= NOP_INSTR;
      ifid_q.pc       <= '0;
      ifid_q.pc_plus4 <= '0;
      ifid_q.valid    <= 1'b0;
    end else if (bubble) begin
      ifid_q.instr <= NOP_INSTR;
      ifid_q.valid <= 1'b0;
    end else if (load) begin
      ifid_q <= data;
    end
  end

  assign ifid = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, RUN/HALT control, fetch counter and IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = XLEN,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_f_q, pc_f_d;
  logic                  misaligned_q, misaligned_d;
  logic [31:0]           fetch_count_q, fetch_count_d;

  logic                  ifid_load;
  logic                  ifid_bubble;
  if_id_t                ifid_data;
  if_id_t                ifid;

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  ecall_in_id;

  assign pc_plus4    = pc_f_q + DATA_WIDTH'(4);
  assign ecall_in_id = ifid.valid && (ifid.instr == ECALL_INSTR);

  assign ifid_data.instr    = bus.imem_rdata;
  assign ifid_data.pc       = pc_f_q;
  assign ifid_data.pc_plus4 = pc_plus4;
  assign ifid_data.valid    = 1'b1;

  // State, PC, sticky misaligned flag and fetch counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_f_q        <= RESET_PC;
      misaligned_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_f_q        <= pc_f_d;
      misaligned_q  <= misaligned_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Per-cycle decision in RUN, first matching rule wins; HALT freezes everything.
  always_comb begin
    state_d       = state_q;
    pc_f_d        = pc_f_q;
    misaligned_d  = misaligned_q;
    fetch_count_d = fetch_count_q;
    ifid_load     = 1'b0;
    ifid_bubble   = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.flush && bus.pc_target[1]) begin
          misaligned_d = 1'b1;
          ifid_bubble  = 1'b1;
          state_d      = HALT;
        end else if (bus.flush) begin
          pc_f_d      = redirect_pc(bus.pc_target);
          ifid_bubble = 1'b1;
        end else if (!bus.stall && ecall_in_id) begin
          ifid_bubble = 1'b1;
          state_d     = HALT;
        end else if (bus.stall) begin
          // hold everything
        end else begin
          pc_f_d        = pc_plus4;
          ifid_load     = 1'b1;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      HALT: begin
        // only reset leaves HALT
      end
      default: state_d = RUN;
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .data   (ifid_data),
    .ifid   (ifid)
  );

  assign bus.imem_addr   = pc_f_q;
  assign bus.instr_d     = ifid.instr;
  assign bus.pc_d        = ifid.pc;
  assign bus.pc_plus4_d  = ifid.pc_plus4;
  assign bus.valid_d     = ifid.valid;
  assign bus.halted      = (state_q == HALT);
  assign bus.misaligned  = misaligned_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: vectors push expected state, a monitor pops and compares.
module tb_fetch_stage;

  logic clk;
  logic rst_a_n;
  logic rst_b_n;

  fetch_stage_if #(.DATA_WIDTH(32)) bus_a();
  fetch_stage_if #(.DATA_WIDTH(32)) bus_b();

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut_a (
    .clk   (clk),
    .rst_n (rst_a_n),
    .bus   (bus_a)
  );

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk   (clk),
    .rst_n (rst_b_n),
    .bus   (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction ROM contents.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h00: return 32'h0050_0093;
      32'h04: return 32'h0010_0113;
      32'h08: return 32'h0020_0193;
      32'h0C: return 32'h0030_0213;
      32'h40: return 32'h0040_0293;
      32'h44: return 32'h0000_0073;
      32'h48: return 32'h0050_0313;
      32'h80: return 32'h0060_0393;
      32'h84: return 32'h0070_0413;
      default: return 32'h0FF0_0013;
    endcase
  endfunction

  always_comb bus_a.imem_rdata = rom(bus_a.imem_addr);
  always_comb bus_b.imem_rdata = rom(bus_b.imem_addr);

  typedef struct {
    bit          sel_b;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pc4;
    logic        v;
    logic        h;
    logic        m;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL txn %0d %s: got %h expected %h", txn, name, act, req);
    end
  endtask

  // Monitor: compares the DUT state after each edge against the oldest expectation.
  initial begin
    exp_t        e;
    logic [31:0] pc, instr, pcd, pc4, cnt;
    logic        v, h, m;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.sel_b) begin
          pc = bus_b.imem_addr; instr = bus_b.instr_d; pcd = bus_b.pc_d;
          pc4 = bus_b.pc_plus4_d; v = bus_b.valid_d; h = bus_b.halted;
          m = bus_b.misaligned; cnt = bus_b.fetch_count;
        end else begin
          pc = bus_a.imem_addr; instr = bus_a.instr_d; pcd = bus_a.pc_d;
          pc4 = bus_a.pc_plus4_d; v = bus_a.valid_d; h = bus_a.halted;
          m = bus_a.misaligned; cnt = bus_a.fetch_count;
        end
        $display("txn %0d dut=%s pc_f=%h instr_d=%h pc_d=%h pc_plus4_d=%h valid=%b halted=%b mis=%b count=%0d",
                 txn, e.sel_b ? "B" : "A", pc, instr, pcd, pc4, v, h, m, cnt);
        check("pc_f",        pc,           e.pc);
        check("instr_d",     instr,        e.instr);
        check("pc_d",        pcd,          e.pcd);
        check("pc_plus4_d",  pc4,          e.pc4);
        check("valid_d",     32'(v),       32'(e.v));
        check("halted",      32'(h),       32'(e.h));
        check("misaligned",  32'(m),       32'(e.m));
        check("fetch_count", cnt,          e.cnt);
        txn++;
      end
    end
  end

  // One clock of stimulus: drive inputs on the falling edge and queue the state expected after the next rising edge.
  task automatic vec(input bit sel_b, input logic rst, input logic stall, input logic flush,
                     input logic [31:0] target,
                     input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] pcd,
                     input logic [31:0] pc4, input logic v, input logic h, input logic m,
                     input logic [31:0] cnt);
    exp_t e;
    if (sel_b) begin
      rst_b_n = rst; bus_b.stall = stall; bus_b.flush = flush; bus_b.pc_target = target;
    end else begin
      rst_a_n = rst; bus_a.stall = stall; bus_a.flush = flush; bus_a.pc_target = target;
    end
    e.sel_b = sel_b; e.pc = pc; e.instr = instr; e.pcd = pcd; e.pc4 = pc4;
    e.v = v; e.h = h; e.m = m; e.cnt = cnt;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    bus_a.stall = 1'b0; bus_a.flush = 1'b0; bus_a.pc_target = '0;
    bus_b.stall = 1'b0; bus_b.flush = 1'b0; bus_b.pc_target = '0;
    @(negedge clk);

    //   B  rst stl fl  target        pc_f          instr         pc_d          pc+4          v  h  m  count
    // reset, then free-run
    vec(0, 0, 0, 0, 32'h0,  32'h00, 32'h0000_0013, 32'h00, 32'h00, 0, 0, 0, 0);
    vec(0, 1, 0, 0, 32'h0,  32'h04, 32'h0050_0093, 32'h00, 32'h04, 1, 0, 0, 1);
    vec(0, 1, 0, 0, 32'h0,  32'h08, 32'h0010_0113, 32'h04, 32'h08, 1, 0, 0, 2);
    // three-cycle stall at pc_f=8, then resume
    vec(0, 1, 1, 0, 32'h0,  32'h08, 32'h0010_0113, 32'h04, 32'h08, 1, 0, 0, 2);
    vec(0, 1, 1, 0, 32'h0,  32'h08, 32'h0010_0113, 32'h04, 32'h08, 1, 0, 0, 2);
    vec(0, 1, 1, 0, 32'h0,  32'h08, 32'h0010_0113, 32'h04, 32'h08, 1, 0, 0, 2);
    vec(0, 1, 0, 0, 32'h0,  32'h0C, 32'h0020_0193, 32'h08, 32'h0C, 1, 0, 0, 3);
    // flush beats stall, target bit 0 cleared
    vec(0, 1, 1, 1, 32'h41, 32'h40, 32'h0000_0013, 32'h08, 32'h0C, 0, 0, 0, 3);
    vec(0, 1, 0, 0, 32'h0,  32'h44, 32'h0040_0293, 32'h40, 32'h44, 1, 0, 0, 4);
    vec(0, 1, 0, 0, 32'h0,  32'h48, 32'h0000_0073, 32'h44, 32'h48, 1, 0, 0, 5);
    // ecall in IF/ID squashed by flush: redirect, no halt
    vec(0, 1, 0, 1, 32'h80, 32'h80, 32'h0000_0013, 32'h44, 32'h48, 0, 0, 0, 5);
    vec(0, 1, 0, 0, 32'h0,  32'h84, 32'h0060_0393, 32'h80, 32'h84, 1, 0, 0, 6);
    vec(0, 1, 0, 1, 32'h40, 32'h40, 32'h0000_0013, 32'h80, 32'h84, 0, 0, 0, 6);
    vec(0, 1, 0, 0, 32'h0,  32'h44, 32'h0040_0293, 32'h40, 32'h44, 1, 0, 0, 7);
    vec(0, 1, 0, 0, 32'h0,  32'h48, 32'h0000_0073, 32'h44, 32'h48, 1, 0, 0, 8);
    // ecall under stall holds; released stall halts
    vec(0, 1, 1, 0, 32'h0,  32'h48, 32'h0000_0073, 32'h44, 32'h48, 1, 0, 0, 8);
    vec(0, 1, 0, 0, 32'h0,  32'h48, 32'h0000_0013, 32'h44, 32'h48, 0, 1, 0, 8);
    vec(0, 1, 0, 1, 32'h80, 32'h48, 32'h0000_0013, 32'h44, 32'h48, 0, 1, 0, 8);
    vec(0, 1, 0, 0, 32'h0,  32'h48, 32'h0000_0013, 32'h44, 32'h48, 0, 1, 0, 8);
    // reset out of HALT
    vec(0, 0, 0, 0, 32'h0,  32'h00, 32'h0000_0013, 32'h00, 32'h00, 0, 0, 0, 0);
    vec(0, 1, 0, 0, 32'h0,  32'h04, 32'h0050_0093, 32'h00, 32'h04, 1, 0, 0, 1);
    vec(0, 1, 0, 0, 32'h0,  32'h08, 32'h0010_0113, 32'h04, 32'h08, 1, 0, 0, 2);
    // misaligned redirect target
    vec(0, 1, 0, 1, 32'h22, 32'h08, 32'h0000_0013, 32'h04, 32'h08, 0, 1, 1, 2);
    vec(0, 1, 0, 0, 32'h0,  32'h08, 32'h0000_0013, 32'h04, 32'h08, 0, 1, 1, 2);
    vec(0, 1, 0, 1, 32'h40, 32'h08, 32'h0000_0013, 32'h04, 32'h08, 0, 1, 1, 2);
    // reset with stall asserted, then stalled, then advance
    vec(0, 0, 1, 0, 32'h0,  32'h00, 32'h0000_0013, 32'h00, 32'h00, 0, 0, 0, 0);
    vec(0, 1, 1, 0, 32'h0,  32'h00, 32'h0000_0013, 32'h00, 32'h00, 0, 0, 0, 0);
    vec(0, 1, 0, 0, 32'h0,  32'h04, 32'h0050_0093, 32'h00, 32'h04, 1, 0, 0, 1);
    // second instance: reset PC at the top of the address space wraps to 0
    vec(1, 0, 0, 0, 32'h0,  32'hFFFF_FFFC, 32'h0000_0013, 32'h0000_0000, 32'h00, 0, 0, 0, 0);
    vec(1, 1, 0, 0, 32'h0,  32'h0000_0000, 32'h0FF0_0013, 32'hFFFF_FFFC, 32'h00, 1, 0, 0, 1);
    vec(1, 1, 0, 0, 32'h0,  32'h0000_0004, 32'h0050_0093, 32'h0000_0000, 32'h04, 1, 0, 0, 2);

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RV32I core, directly upstream of `controlunit`. It owns the program counter and reads the instruction ROM combinationally. It registers the fetched word into the IF/ID pipeline register; that register's `instr_d` output is the `instr` input of `controlunit`. It also handles stall, branch/jump redirect, bubble insertion, and halting on `ecall` or a misaligned redirect target.

## Interface
- `DATA_WIDTH`, 32, instruction/address width.
- `RESET_PC`, 32'h0000_0000, PC value loaded by reset.

- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `stall`  in  1  from hazard unit; hold PC and IF/ID.
- `flush`  in  1  branch/jump taken in EX; redirect PC and squash IF/ID.
- `pc_target`  in  DATA_WIDTH  redirect address from EX (branch or JAL/JALR result).
- `imem_addr`  out  DATA_WIDTH  equals `pc_f`; ROM address.
- `imem_rdata`  in  DATA_WIDTH  ROM word at `imem_addr`, valid same cycle.
- `instr_d`  out  DATA_WIDTH  IF/ID instruction; feeds `controlunit.instr`.
- `pc_d`  out  DATA_WIDTH  PC of `instr_d`.
- `pc_plus4_d`  out  DATA_WIDTH  `pc_d + 4`; used as the JAL/JALR link value.
- `valid_d`  out  1  `instr_d` is a real instruction, not a bubble.
- `halted`  out  1  stage is in HALT.
- `misaligned`  out  1  sticky: a redirect target had bit 1 set.
- `fetch_count`  out  32  number of instructions accepted into IF/ID; wraps modulo 2^32.

## Operation
- State machine with two states: RUN and HALT. Reset enters RUN.
- Each RUN cycle is decided by the first rule that matches:
  1. **Misaligned redirect.** Condition: `flush` and `pc_target[1]==1`. Set `misaligned`, load a bubble into IF/ID, hold PC, go to HALT.
  2. **Flush.** Condition: `flush`. Load `pc_f <= {pc_target[31:1],1'b0}` (bit 0 cleared, matching JALR semantics). Load a bubble into IF/ID. `flush` overrides `stall`.
  3. **Halt on ecall.** Condition: `!stall`, `valid_d`, and `instr_d==32'h0000_0073`. Load a bubble into IF/ID, hold PC, go to HALT. An `ecall` squashed by `flush` in the same cycle never halts.
  4. **Stall.** Condition: `stall`. Hold `pc_f`, all IF/ID fields, and `fetch_count`.
  5. **Advance.** Otherwise: `pc_f <= pc_f+4`; IF/ID `<= {imem_rdata, pc_f, pc_f+4, valid=1}`; `fetch_count++`.
- Bubble: `instr_d=32'h0000_0013` (ADDI x0,x0,0), `valid_d=0`. `pc_d` and `pc_plus4_d` are held at their previous values.
- HALT: PC and IF/ID are frozen with a bubble. `stall` and `flush` are ignored. `halted=1`. Only reset leaves HALT.
- PC arithmetic is modulo 2^DATA_WIDTH; `32'hFFFF_FFFC + 4` wraps to 0 without a flag.

## Timing
- Reset, sampled on a `clk` edge with `rst_n==0`, sets:
  - `pc_f=RESET_PC`
  - `instr_d=32'h0000_0013`, `pc_d=0`, `pc_plus4_d=0`, `valid_d=0`
  - `halted=0`, `misaligned=0`, `fetch_count=0`
  - state RUN
- Reset has priority over every other input, including mid-stall and in HALT.
- `imem_addr` is combinational from `pc_f`. Fetch latency is 1 cycle: the word at PC P appears on `instr_d` on the edge after `pc_f==P`, provided there is no stall or flush.
- Redirect: `flush` sampled at edge N gives `pc_f=target` after edge N. The target instruction appears on `instr_d` after edge N+1. Exactly one bubble is inserted.
- `halted` and `misaligned` are registered and assert the cycle after the triggering edge.

## Structure
- Package `fetch_pkg`: `NOP_INSTR`, `ECALL_INSTR`, `fetch_state_t` enum {RUN, HALT}, and the IF/ID struct type.
- Sub-module `if_id_reg`: IF/ID register. Inputs: `load`, `bubble`, data. Bubble has priority over load; neither asserted means hold.
- `fetch_stage` contains the PC register, state machine, counter, and priority logic.

## Test plan
- **Reset then free-run.** ROM holds `0x00500093` at address 0 and `0x00100113` at address 4. Expect:
  - after edge 1: `instr_d=0x00500093`, `pc_d=0`, `valid_d=1`
  - after edge 2: `instr_d=0x00100113`, `pc_d=4`, `pc_plus4_d=8`, `fetch_count=2`
- **Stall.** Assert `stall` for 3 cycles at `pc_f=8`. Expect `pc_f`, `instr_d`, and `fetch_count` unchanged; on release, fetch resumes at 8.
- **Flush beats stall.** Assert `flush` and `stall` together with `pc_target=0x41`. Expect:
  - next cycle: `pc_f=0x40`, `instr_d=0x13`, `valid_d=0`
  - following cycle: the word at `0x40` on `instr_d`
- **Misaligned.** `flush` with `pc_target=0x22`. Expect `misaligned=1`, `halted=1`, `pc_f` unchanged, and `valid_d` held at 0 thereafter.
- **ecall halt and squash.** Case 1: `instr_d=0x00000073` with no flush. Expect `halted=1`, `fetch_count` frozen, `pc_f` frozen. Case 2: the same `instr_d` with `flush=1`. Expect no halt and a redirect to target.
- **Reset mid-HALT and PC wrap.** Pulse `rst_n=0` while in HALT. Expect all reset values and `pc_f=RESET_PC`. Separately, with `RESET_PC=32'hFFFF_FFFC`, expect `pc_f` to wrap to 0 after one advance.
